// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush scheduler for the 5-stage pipeline.
// It decides which pipeline registers load, which ones flush, and what
// the PC loads next. It also owns the mult/div busy counter and the
// EXL flag.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   load_use          D-stage instruction depends on an E-stage load
//   d_uses_md         D-stage instruction touches the mult/div unit
//   md_start          E-stage instruction issues mult/div this cycle
//   md_is_div         qualifies md_start: 1 = div/divu
//   d_pc              PC of the D-stage instruction (stall bubble PC)
//   exc_m             synchronous exception in M stage
//   int_req, ie       interrupt request and global enable
//   eret_m            eret in M stage
//   epc               return target for eret
//   en_pc, en_fd, en_de, en_em, en_mw   register enables
//   flush_fd, flush_de, flush_em        flush-with-PC requests
//   bubble_pc         PC written into flushed registers
//   redirect          PC loads redirect_pc at the next edge
//   redirect_pc       redirect target
//   md_busy           mult/div unit busy
//   exl               exception level flag
//   exc_take          exception/interrupt accepted this cycle
// Optional (`define PIPE_STATS_EN):
//   stall_cycles      count of plain stall cycles
//   flush_events      count of take/eret cycles
module pipe_hazard_ctrl #(
  parameter int          MULT_CYCLES = 5,
  parameter int          DIV_CYCLES  = 10,
  parameter logic [31:0] EXC_VECTOR  = 32'h00004180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_use,
  input  logic        d_uses_md,
  input  logic        md_start,
  input  logic        md_is_div,
  input  logic [31:0] d_pc,
  input  logic        exc_m,
  input  logic        int_req,
  input  logic        ie,
  input  logic        eret_m,
  input  logic [31:0] epc,
  output logic        en_pc,
  output logic        en_fd,
  output logic        en_de,
  output logic        en_em,
  output logic        en_mw,
  output logic        flush_fd,
  output logic        flush_de,
  output logic        flush_em,
  output logic [31:0] bubble_pc,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        md_busy,
  output logic        exl,
  output logic        exc_take
`ifdef PIPE_STATS_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
`endif
);

  localparam int MAXC   = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CW_RAW = $clog2(MAXC + 1);
  localparam int CW     = (CW_RAW < 4) ? 4 : CW_RAW;

  logic [CW-1:0] md_cnt;
  logic          take;
  logic          stall;

  assign take    = exc_m | (int_req & ie & ~exl);
  assign md_busy = (md_cnt != '0);
  // md_start counts as busy in its issue cycle, so a dependent D-stage
  // instruction stalls before the counter is even loaded.
  assign stall   = load_use | (d_uses_md & (md_busy | md_start));

  // Priority: take > eret > stall > run.
  always_comb begin
    en_pc       = 1'b1;
    en_fd       = 1'b1;
    en_de       = 1'b1;
    en_em       = 1'b1;
    en_mw       = 1'b1;
    flush_fd    = 1'b0;
    flush_de    = 1'b0;
    flush_em    = 1'b0;
    bubble_pc   = 32'h0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    exc_take    = 1'b0;
    if (take) begin
      exc_take    = 1'b1;
      flush_fd    = 1'b1;
      flush_de    = 1'b1;
      flush_em    = 1'b1;
      redirect    = 1'b1;
      redirect_pc = EXC_VECTOR;
      bubble_pc   = EXC_VECTOR;
    end else if (eret_m) begin
      flush_fd    = 1'b1;
      flush_de    = 1'b1;
      flush_em    = 1'b1;
      redirect    = 1'b1;
      redirect_pc = epc;
      bubble_pc   = epc;
    end else if (stall) begin
      // Hold PC and F/D; D/E stays enabled so the flush inserts a bubble.
      en_pc     = 1'b0;
      en_fd     = 1'b0;
      flush_de  = 1'b1;
      bubble_pc = d_pc;
    end
  end

  // An in-flight mult/div keeps counting through take/eret; only an
  // issue that is itself being flushed (take) is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt <= '0;
      exl    <= 1'b0;
    end else begin
      if (md_start && !take)
        md_cnt <= md_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      else if (md_busy)
        md_cnt <= md_cnt - 1'b1;
      if (take)
        exl <= 1'b1;
      else if (eret_m)
        exl <= 1'b0;
    end
  end

`ifdef PIPE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= 32'h0;
      flush_events <= 32'h0;
    end else begin
      if (stall && !take && !eret_m)
        stall_cycles <= stall_cycles + 32'd1;
      if (take || eret_m)
        flush_events <= flush_events + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        load_use, d_uses_md, md_start, md_is_div;
  logic [31:0] d_pc, epc;
  logic        exc_m, int_req, ie, eret_m;
  logic        en_pc, en_fd, en_de, en_em, en_mw;
  logic        flush_fd, flush_de, flush_em;
  logic [31:0] bubble_pc, redirect_pc;
  logic        redirect, md_busy, exl, exc_take;
`ifdef PIPE_STATS_EN
  logic [31:0] stall_cycles, flush_events;
`endif

  int checks   = 0;
  int failures = 0;
  int n;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .reset(reset), .load_use(load_use), .d_uses_md(d_uses_md),
    .md_start(md_start), .md_is_div(md_is_div), .d_pc(d_pc), .exc_m(exc_m),
    .int_req(int_req), .ie(ie), .eret_m(eret_m), .epc(epc),
    .en_pc(en_pc), .en_fd(en_fd), .en_de(en_de), .en_em(en_em), .en_mw(en_mw),
    .flush_fd(flush_fd), .flush_de(flush_de), .flush_em(flush_em),
    .bubble_pc(bubble_pc), .redirect(redirect), .redirect_pc(redirect_pc),
    .md_busy(md_busy), .exl(exl), .exc_take(exc_take)
`ifdef PIPE_STATS_EN
    , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // advance one edge; inputs change and outputs are sampled mid-cycle
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] ens();
    return {27'h0, en_pc, en_fd, en_de, en_em, en_mw};
  endfunction

  function automatic logic [31:0] fls();
    return {29'h0, flush_fd, flush_de, flush_em};
  endfunction

  initial begin
    reset = 1'b1;
    {load_use, d_uses_md, md_start, md_is_div, exc_m, int_req, ie, eret_m} = '0;
    d_pc = 32'h0; epc = 32'h0;
    #2;
    repeat (3) step();
    reset = 1'b0;
    step();

    // reset state
    chk("rst_en",     ens(), 32'h1f);
    chk("rst_flush",  fls(), 32'h0);
    chk("rst_busy",   {31'h0, md_busy}, 32'h0);
    chk("rst_exl",    {31'h0, exl}, 32'h0);
    chk("rst_redir",  {31'h0, redirect}, 32'h0);
    chk("rst_bubble", bubble_pc, 32'h0);
    chk("rst_take",   {31'h0, exc_take}, 32'h0);

    // load-use stall
    load_use = 1'b1; d_pc = 32'h3010; #1;
    chk("lu_en",     ens(), 32'h07);
    chk("lu_flush",  fls(), 32'h2);
    chk("lu_bubble", bubble_pc, 32'h3010);
    step();
    load_use = 1'b0; #1;
    chk("lu_run_en",     ens(), 32'h1f);
    chk("lu_run_bubble", bubble_pc, 32'h0);

    // divide: issue cycle + 10 busy cycles of stall
    md_start = 1'b1; md_is_div = 1'b1; d_uses_md = 1'b1; #1;
    chk("div_issue_busy", {31'h0, md_busy}, 32'h0);
    n = 0;
    while (!en_pc && n < 30) begin
      n++;
      step();
      md_start = 1'b0; #1;
    end
    chk("div_stall_len", n, 32'd11);
    chk("div_busy_end",  {31'h0, md_busy}, 32'h0);
    d_uses_md = 1'b0; md_is_div = 1'b0;

    // multiply: busy for 5 cycles after issue
    md_start = 1'b1; step(); md_start = 1'b0; #1;
    n = 0;
    while (md_busy && n < 30) begin
      n++;
      step();
    end
    chk("mul_busy_len", n, 32'd5);

    // interrupt gated by ie
    int_req = 1'b1; #1;
    chk("int_noie_take", {31'h0, exc_take}, 32'h0);
    ie = 1'b1; #1;
    chk("int_take",      {31'h0, exc_take}, 32'h1);
    chk("int_redir",     {31'h0, redirect}, 32'h1);
    chk("int_redir_pc",  redirect_pc, 32'h4180);
    chk("int_bubble",    bubble_pc, 32'h4180);
    chk("int_flush",     fls(), 32'h7);
    chk("int_en",        ens(), 32'h1f);
    step();
    chk("int_exl",       {31'h0, exl}, 32'h1);
    chk("int_retake",    {31'h0, exc_take}, 32'h0);
    step();
    chk("int_retake2",   {31'h0, exc_take}, 32'h0);
    int_req = 1'b0; ie = 1'b0;

    // exc_m and eret together: take wins, exl stays 1
    exc_m = 1'b1; eret_m = 1'b1; epc = 32'h3020; #1;
    chk("both_take",     {31'h0, exc_take}, 32'h1);
    chk("both_redir_pc", redirect_pc, 32'h4180);
    step();
    chk("both_exl",      {31'h0, exl}, 32'h1);
    exc_m = 1'b0; load_use = 1'b1; #1;
    // eret alone, outranking a load-use stall
    chk("eret_take",     {31'h0, exc_take}, 32'h0);
    chk("eret_redir_pc", redirect_pc, 32'h3020);
    chk("eret_bubble",   bubble_pc, 32'h3020);
    chk("eret_flush",    fls(), 32'h7);
    chk("eret_en",       ens(), 32'h1f);
    step();
    eret_m = 1'b0; load_use = 1'b0; #1;
    chk("eret_exl",      {31'h0, exl}, 32'h0);

    // md_start under a take never starts the counter
    md_start = 1'b1; md_is_div = 1'b1; exc_m = 1'b1; step();
    md_start = 1'b0; exc_m = 1'b0; #1;
    chk("take_md_busy",  {31'h0, md_busy}, 32'h0);
    chk("take_md_exl",   {31'h0, exl}, 32'h1);

    // reset mid-divide clears counter and exl
    md_start = 1'b1; step(); md_start = 1'b0; step();
    chk("mid_div_busy",  {31'h0, md_busy}, 32'h1);
    reset = 1'b1; step(); reset = 1'b0; #1;
    chk("rst_mid_busy",  {31'h0, md_busy}, 32'h0);
    chk("rst_mid_exl",   {31'h0, exl}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush scheduler for the 5-stage pipeline. It drives the enable and flush-with-PC controls of the F/D, D/E, E/M and M/W pipeline registers, and the PC enable and redirect.
- Arbitrates load-use stalls, multiply/divide busy stalls, exception/interrupt entry and eret return.
- Owns the mult/div busy counter and the EXL (exception level) flag.

Parameters:
MULT_CYCLES, 5, busy cycles after a mult/multu issue
DIV_CYCLES, 10, busy cycles after a div/divu issue
EXC_VECTOR, 32'h00004180, handler entry PC

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
load_use  in  1  D-stage instruction reads a register loaded by the E-stage instruction
d_uses_md  in  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo
md_start  in  1  E-stage instruction issues mult/div this cycle
md_is_div  in  1  qualifies md_start: 1 = div/divu
d_pc  in  32  PC of the D-stage instruction
exc_m  in  1  synchronous exception detected in M stage
int_req  in  1  external interrupt pending (level)
ie  in  1  global interrupt enable from CP0
eret_m  in  1  eret in M stage
epc  in  32  CP0 EPC
en_pc  out  1  PC register enable
en_fd, en_de, en_em, en_mw  out  1 each  pipeline register enables
flush_fd, flush_de, flush_em  out  1 each  flush-with-PC requests
bubble_pc  out  32  PC written into flushed registers
redirect  out  1  PC loads redirect_pc next edge
redirect_pc  out  32  redirect target
md_busy  out  1  mult/div unit busy
exl  out  1  exception level flag
exc_take  out  1  exception/interrupt accepted this cycle

Behaviour:
- Registered state: md_cnt (4 bits min), exl. All other outputs are combinational from inputs and state.
- Reset: md_cnt=0, exl=0. With all inputs low: md_busy=0, all enables=1, all flushes=0, redirect=0, bubble_pc=0, exc_take=0.
- take = exc_m | (int_req & ie & ~exl).
- Priority: take > eret_m > stall > run.
- take:
  - exc_take=1, flush_fd=flush_de=flush_em=1, redirect=1, redirect_pc=EXC_VECTOR, bubble_pc=EXC_VECTOR.
  - All enables=1; en_mw=1 with the M-stage instruction not committed is the datapath's job.
  - Next edge: exl<=1.
  - md_start is ignored this cycle, so a flushed E instruction never starts the counter.
- eret_m (no take):
  - flush_fd/de/em=1, redirect=1, redirect_pc=epc, bubble_pc=epc.
  - Next edge: exl<=0.
- stall = load_use | (d_uses_md & (md_busy | md_start)):
  - en_pc=0, en_fd=0, flush_de=1, bubble_pc=d_pc.
  - en_em=en_mw=1; en_de=1, so the flush writes a bubble.
- run: all enables 1, no flush, bubble_pc=0.
- md counter:
  - On md_start & ~take: md_cnt <= (md_is_div ? DIV_CYCLES : MULT_CYCLES).
  - Otherwise, if md_cnt != 0, it decrements.
  - md_busy = (md_cnt != 0).
  - md_start while md_busy reloads the counter (restart).
  - Counter is not cleared by take or eret; an in-flight operation completes.
- exl blocks further interrupts but not exc_m. take & eret_m in the same cycle: take wins, exl ends at 1.
- Reset has priority over every event, including mid-stall and mid-md.

Optional Feature:
PIPE_STATS_EN
- Defined: adds outputs stall_cycles[31:0] and flush_events[31:0].
  - stall_cycles increments on every stall cycle that has no take and no eret.
  - flush_events increments once per take or eret cycle.
  - Both clear on reset and wrap modulo 2^32.
- Undefined: no counters and no extra ports; all other behaviour is identical.

Test Plan:
- Reset 3 cycles, inputs 0 -> all enables 1, flushes 0, md_busy 0, exl 0.
- load_use=1, d_pc=0x3010 for 1 cycle -> en_pc=en_fd=0, flush_de=1, bubble_pc=0x3010; next cycle run.
- md_start=1, md_is_div=1, then d_uses_md=1 held -> stall for exactly 11 cycles (issue cycle + 10 busy); md_busy falls after the 10th edge.
- int_req=1, ie=1 -> exc_take=1, redirect_pc=0x4180, flush_fd/de/em=1; exl=1 next cycle. int_req held -> no second take.
- exc_m=1 and eret_m=1 together with epc=0x3020 -> redirect_pc=0x4180 and exl=1. Then eret_m alone -> redirect_pc=0x3020 and exl=0.
- md_start=1 same cycle as exc_m=1 -> md_busy stays 0. Reset asserted mid-div -> md_busy 0 next cycle.
